// File: rtl/rs_alu_if.sv
// Purpose: issue, broadcast, control and dispatch signals of the ALU reservation station.
// Latency: none; this is wiring only.
// Backpressure: the station raises full when it has no free entry, and the core holds everything back by dropping rdy.
interface rs_alu_if #(
    parameter int OP_LOG  = 6,
    parameter int ROB_LOG = 4
);
    // global control
    logic               rdy;
    logic               jump_flag;
    // issue from decode
    logic               issue_en;
    logic [OP_LOG-1:0]  issue_op;
    logic [31:0]        issue_Imm;
    logic [31:0]        issue_CurPC;
    logic [ROB_LOG-1:0] issue_DestRob;
    logic [31:0]        issue_Vj;
    logic [31:0]        issue_Vk;
    logic               issue_Qj_pend;
    logic               issue_Qk_pend;
    logic [ROB_LOG-1:0] issue_Qj;
    logic [ROB_LOG-1:0] issue_Qk;
    // result broadcasts
    logic               B_enable;
    logic [31:0]        B_value;
    logic [ROB_LOG-1:0] B_RobId;
    logic               LSB_enable;
    logic [31:0]        LSB_value;
    logic [ROB_LOG-1:0] LSB_RobId;
    // status and dispatch
    logic               full;
    logic               RS_valid;
    logic [OP_LOG-1:0]  RS_op;
    logic [31:0]        RS_Vj;
    logic [31:0]        RS_Vk;
    logic [31:0]        RS_Imm;
    logic [31:0]        RS_CurPC;
    logic [ROB_LOG-1:0] RS_DestRob;

    modport master (
        output rdy, jump_flag,
        output issue_en, issue_op, issue_Imm, issue_CurPC, issue_DestRob,
        output issue_Vj, issue_Vk, issue_Qj_pend, issue_Qk_pend, issue_Qj, issue_Qk,
        output B_enable, B_value, B_RobId, LSB_enable, LSB_value, LSB_RobId,
        input  full, RS_valid, RS_op, RS_Vj, RS_Vk, RS_Imm, RS_CurPC, RS_DestRob
    );

    modport slave (
        input  rdy, jump_flag,
        input  issue_en, issue_op, issue_Imm, issue_CurPC, issue_DestRob,
        input  issue_Vj, issue_Vk, issue_Qj_pend, issue_Qk_pend, issue_Qj, issue_Qk,
        input  B_enable, B_value, B_RobId, LSB_enable, LSB_value, LSB_RobId,
        output full, RS_valid, RS_op, RS_Vj, RS_Vk, RS_Imm, RS_CurPC, RS_DestRob
    );
endinterface

// File: rtl/rs_alu.sv
// Purpose: ALU/branch reservation station that snoops CDB broadcasts and dispatches the oldest-slot ready entry.
// Latency: an instruction issued ready dispatches on the next edge, so RS_valid is seen 2 edges after issue; a woken operand dispatches 1 edge later.
// Backpressure: full blocks issue; rdy=0 freezes the station; jump_flag flushes it.
module rs_alu #(
    parameter int RS_SIZE = 16,
    parameter int OP_LOG  = 6,
    parameter int ROB_LOG = 4
) (
    input  logic   clk,
    input  logic   rst,
    rs_alu_if.slave bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam logic [OP_LOG-1:0] OP_NOP = '0;

    typedef struct packed {
        logic               busy;
        logic [OP_LOG-1:0]  op;
        logic [31:0]        vj;
        logic [31:0]        vk;
        logic [ROB_LOG-1:0] qj;
        logic [ROB_LOG-1:0] qk;
        logic               qj_pend;
        logic               qk_pend;
        logic [31:0]        imm;
        logic [ROB_LOG-1:0] dest_rob;
        logic [31:0]        cur_pc;
    } entry_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];
    entry_t new_ent;

    logic               rs_valid_q, rs_valid_d;
    logic [OP_LOG-1:0]  rs_op_q, rs_op_d;
    logic [31:0]        rs_vj_q, rs_vj_d;
    logic [31:0]        rs_vk_q, rs_vk_d;
    logic [31:0]        rs_imm_q, rs_imm_d;
    logic [31:0]        rs_cur_pc_q, rs_cur_pc_d;
    logic [ROB_LOG-1:0] rs_dest_rob_q, rs_dest_rob_d;

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               ready_found;
    logic [IDX_W-1:0]   ready_idx;
    logic               all_busy;

    // Lowest-index free and ready slots, judged only on registered state.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        all_busy    = 1'b1;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
                all_busy   = 1'b0;
            end
            if (ent_q[i].busy && !ent_q[i].qj_pend && !ent_q[i].qk_pend) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end
    end

    assign bus.full = all_busy;

    // Build the incoming entry, picking up a result broadcast in the same cycle.
    always_comb begin
        new_ent          = '0;
        new_ent.busy     = 1'b1;
        new_ent.op       = bus.issue_op;
        new_ent.vj       = bus.issue_Vj;
        new_ent.vk       = bus.issue_Vk;
        new_ent.qj       = bus.issue_Qj;
        new_ent.qk       = bus.issue_Qk;
        new_ent.qj_pend  = bus.issue_Qj_pend;
        new_ent.qk_pend  = bus.issue_Qk_pend;
        new_ent.imm      = bus.issue_Imm;
        new_ent.dest_rob = bus.issue_DestRob;
        new_ent.cur_pc   = bus.issue_CurPC;
        if (bus.issue_Qj_pend) begin
            if (bus.B_enable && bus.issue_Qj == bus.B_RobId) begin
                new_ent.vj      = bus.B_value;
                new_ent.qj_pend = 1'b0;
            end else if (bus.LSB_enable && bus.issue_Qj == bus.LSB_RobId) begin
                new_ent.vj      = bus.LSB_value;
                new_ent.qj_pend = 1'b0;
            end
        end
        if (bus.issue_Qk_pend) begin
            if (bus.B_enable && bus.issue_Qk == bus.B_RobId) begin
                new_ent.vk      = bus.B_value;
                new_ent.qk_pend = 1'b0;
            end else if (bus.LSB_enable && bus.issue_Qk == bus.LSB_RobId) begin
                new_ent.vk      = bus.LSB_value;
                new_ent.qk_pend = 1'b0;
            end
        end
    end

    // Entry update: flush beats stall beats snoop/dispatch/issue.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (bus.jump_flag) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i].busy = 1'b0;
            end
        end else if (bus.rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy && ent_q[i].qj_pend) begin
                    if (bus.B_enable && ent_q[i].qj == bus.B_RobId) begin
                        ent_d[i].vj      = bus.B_value;
                        ent_d[i].qj_pend = 1'b0;
                    end else if (bus.LSB_enable && ent_q[i].qj == bus.LSB_RobId) begin
                        ent_d[i].vj      = bus.LSB_value;
                        ent_d[i].qj_pend = 1'b0;
                    end
                end
                if (ent_q[i].busy && ent_q[i].qk_pend) begin
                    if (bus.B_enable && ent_q[i].qk == bus.B_RobId) begin
                        ent_d[i].vk      = bus.B_value;
                        ent_d[i].qk_pend = 1'b0;
                    end else if (bus.LSB_enable && ent_q[i].qk == bus.LSB_RobId) begin
                        ent_d[i].vk      = bus.LSB_value;
                        ent_d[i].qk_pend = 1'b0;
                    end
                end
            end
            // The dispatched slot was busy and the issue slot was free, so they never collide.
            if (ready_found) begin
                ent_d[ready_idx].busy = 1'b0;
            end
            if (bus.issue_en && free_found) begin
                ent_d[free_idx] = new_ent;
            end
        end
    end

    // Dispatch register: load the selected entry, otherwise drop valid and show NOP.
    always_comb begin
        rs_valid_d    = 1'b0;
        rs_op_d       = rs_op_q;
        rs_vj_d       = rs_vj_q;
        rs_vk_d       = rs_vk_q;
        rs_imm_d      = rs_imm_q;
        rs_cur_pc_d   = rs_cur_pc_q;
        rs_dest_rob_d = rs_dest_rob_q;
        if (bus.jump_flag) begin
            rs_op_d = OP_NOP;
        end else if (bus.rdy) begin
            if (ready_found) begin
                rs_valid_d    = 1'b1;
                rs_op_d       = ent_q[ready_idx].op;
                rs_vj_d       = ent_q[ready_idx].vj;
                rs_vk_d       = ent_q[ready_idx].vk;
                rs_imm_d      = ent_q[ready_idx].imm;
                rs_cur_pc_d   = ent_q[ready_idx].cur_pc;
                rs_dest_rob_d = ent_q[ready_idx].dest_rob;
            end else begin
                rs_op_d = OP_NOP;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            rs_valid_q    <= 1'b0;
            rs_op_q       <= OP_NOP;
            rs_vj_q       <= '0;
            rs_vk_q       <= '0;
            rs_imm_q      <= '0;
            rs_cur_pc_q   <= '0;
            rs_dest_rob_q <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
            rs_valid_q    <= rs_valid_d;
            rs_op_q       <= rs_op_d;
            rs_vj_q       <= rs_vj_d;
            rs_vk_q       <= rs_vk_d;
            rs_imm_q      <= rs_imm_d;
            rs_cur_pc_q   <= rs_cur_pc_d;
            rs_dest_rob_q <= rs_dest_rob_d;
        end
    end

    assign bus.RS_valid   = rs_valid_q;
    assign bus.RS_op      = rs_op_q;
    assign bus.RS_Vj      = rs_vj_q;
    assign bus.RS_Vk      = rs_vk_q;
    assign bus.RS_Imm     = rs_imm_q;
    assign bus.RS_CurPC   = rs_cur_pc_q;
    assign bus.RS_DestRob = rs_dest_rob_q;
endmodule

// File: tb/tb_rs_alu.sv
// Purpose: directed self-checking bench for the ALU reservation station.
// Latency: inputs change 1 time unit after a rising edge, and outputs are sampled at that same point.
// Backpressure: exercises full, rdy stalls, jump flushes and reset.
module tb_rs_alu;
    localparam int OP_LOG  = 6;
    localparam int ROB_LOG = 4;
    localparam logic [OP_LOG-1:0] OP_NOP = 6'd0;
    localparam logic [OP_LOG-1:0] OP_ADD = 6'd1;
    localparam logic [OP_LOG-1:0] OP_SUB = 6'd2;
    localparam logic [OP_LOG-1:0] OP_XOR = 6'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rs_alu_if #(.OP_LOG(OP_LOG), .ROB_LOG(ROB_LOG)) bus ();

    rs_alu #(.RS_SIZE(16), .OP_LOG(OP_LOG), .ROB_LOG(ROB_LOG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.rdy           = 1'b1;
        bus.jump_flag     = 1'b0;
        bus.issue_en      = 1'b0;
        bus.issue_op      = OP_NOP;
        bus.issue_Imm     = '0;
        bus.issue_CurPC   = '0;
        bus.issue_DestRob = '0;
        bus.issue_Vj      = '0;
        bus.issue_Vk      = '0;
        bus.issue_Qj_pend = 1'b0;
        bus.issue_Qk_pend = 1'b0;
        bus.issue_Qj      = '0;
        bus.issue_Qk      = '0;
        bus.B_enable      = 1'b0;
        bus.B_value       = '0;
        bus.B_RobId       = '0;
        bus.LSB_enable    = 1'b0;
        bus.LSB_value     = '0;
        bus.LSB_RobId     = '0;
    endtask

    task automatic issue(input logic [OP_LOG-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjp, input logic [ROB_LOG-1:0] qj,
                         input logic qkp, input logic [ROB_LOG-1:0] qk,
                         input logic [ROB_LOG-1:0] dest);
        bus.issue_en      = 1'b1;
        bus.issue_op      = op;
        bus.issue_Vj      = vj;
        bus.issue_Vk      = vk;
        bus.issue_Qj_pend = qjp;
        bus.issue_Qj      = qj;
        bus.issue_Qk_pend = qkp;
        bus.issue_Qk      = qk;
        bus.issue_DestRob = dest;
        bus.issue_Imm     = 32'h100;
        bus.issue_CurPC   = 32'h2000;
    endtask

    initial begin
        idle();
        // reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_valid", bus.RS_valid, 0);
        check_eq("rst_op", bus.RS_op, OP_NOP);
        check_eq("rst_vj", bus.RS_Vj, 0);
        check_eq("rst_vk", bus.RS_Vk, 0);
        check_eq("rst_dest", bus.RS_DestRob, 0);
        check_eq("rst_full", bus.full, 0);

        // ready issue: dispatch two edges later, never on its own issue edge
        issue(OP_ADD, 5, 7, 0, 0, 0, 0, 3);
        tick();
        idle();
        check_eq("add_no_same_edge", bus.RS_valid, 0);
        tick();
        check_eq("add_valid", bus.RS_valid, 1);
        check_eq("add_op", bus.RS_op, OP_ADD);
        check_eq("add_vj", bus.RS_Vj, 5);
        check_eq("add_vk", bus.RS_Vk, 7);
        check_eq("add_dest", bus.RS_DestRob, 3);
        check_eq("add_imm", bus.RS_Imm, 32'h100);
        check_eq("add_pc", bus.RS_CurPC, 32'h2000);
        tick();
        check_eq("add_one_cycle", bus.RS_valid, 0);
        check_eq("add_nop_after", bus.RS_op, OP_NOP);
        check_eq("add_dest_hold", bus.RS_DestRob, 3);

        // wake through the ALU broadcast
        issue(OP_SUB, 0, 1, 1, 2, 0, 0, 4);
        tick();
        idle();
        bus.B_enable = 1'b1; bus.B_RobId = 2; bus.B_value = 32'h10;
        tick();
        idle();
        check_eq("wake_not_yet", bus.RS_valid, 0);
        tick();
        check_eq("wake_valid", bus.RS_valid, 1);
        check_eq("wake_vj", bus.RS_Vj, 32'h10);
        check_eq("wake_dest", bus.RS_DestRob, 4);
        tick();

        // issue bypass from the load broadcast
        issue(OP_ADD, 0, 2, 1, 4, 0, 0, 5);
        bus.LSB_enable = 1'b1; bus.LSB_RobId = 4; bus.LSB_value = 9;
        tick();
        idle();
        check_eq("byp_no_same_edge", bus.RS_valid, 0);
        tick();
        check_eq("byp_valid", bus.RS_valid, 1);
        check_eq("byp_vj", bus.RS_Vj, 9);
        check_eq("byp_dest", bus.RS_DestRob, 5);
        tick();

        // fill all 16 entries with pending work
        for (int i = 0; i < 16; i++) begin
            issue(OP_SUB, 0, 0, 1, (i == 0) ? 4'd5 : 4'd6, 0, 0, 4'(i));
            tick();
        end
        idle();
        check_eq("fill_full", bus.full, 1);
        issue(OP_XOR, 1, 1, 0, 0, 0, 0, 15);
        tick();
        idle();
        check_eq("over_full", bus.full, 1);
        check_eq("over_no_disp", bus.RS_valid, 0);
        bus.B_enable = 1'b1; bus.B_RobId = 5; bus.B_value = 32'h55;
        tick();
        idle();
        check_eq("over_ignored", bus.RS_valid, 0);
        tick();
        check_eq("e0_valid", bus.RS_valid, 1);
        check_eq("e0_dest", bus.RS_DestRob, 0);
        check_eq("e0_vj", bus.RS_Vj, 32'h55);
        check_eq("e0_full_clear", bus.full, 0);

        // reset mid-operation discards the remaining entries
        rst = 1'b1;
        bus.jump_flag = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check_eq("mid_rst_full", bus.full, 0);
        check_eq("mid_rst_valid", bus.RS_valid, 0);
        check_eq("mid_rst_vj", bus.RS_Vj, 0);
        bus.B_enable = 1'b1; bus.B_RobId = 6; bus.B_value = 32'h66;
        tick();
        idle();
        tick();
        check_eq("mid_rst_no_disp", bus.RS_valid, 0);

        // flush three pending entries, with an issue attempt on the flush edge
        for (int i = 0; i < 3; i++) begin
            issue(OP_ADD, 0, 0, 1, 7, 0, 0, 4'(8 + i));
            tick();
        end
        idle();
        check_eq("pre_jump_full", bus.full, 0);
        bus.jump_flag = 1'b1;
        issue(OP_XOR, 3, 3, 0, 0, 0, 0, 12);
        tick();
        idle();
        check_eq("jump_valid", bus.RS_valid, 0);
        check_eq("jump_op", bus.RS_op, OP_NOP);
        check_eq("jump_full", bus.full, 0);
        bus.B_enable = 1'b1; bus.B_RobId = 7; bus.B_value = 32'h77;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("jump_no_disp", bus.RS_valid, 0);
        end

        // two entries woken together; both operands of the first clear on one edge
        issue(OP_ADD, 0, 0, 1, 8, 1, 9, 1);
        tick();
        issue(OP_SUB, 0, 4, 1, 8, 0, 0, 2);
        tick();
        idle();
        bus.B_enable   = 1'b1; bus.B_RobId   = 8; bus.B_value   = 32'hAA;
        bus.LSB_enable = 1'b1; bus.LSB_RobId = 9; bus.LSB_value = 32'hBB;
        tick();
        idle();
        tick();
        check_eq("pair_first_valid", bus.RS_valid, 1);
        check_eq("pair_first_dest", bus.RS_DestRob, 1);
        check_eq("pair_first_vj", bus.RS_Vj, 32'hAA);
        check_eq("pair_first_vk", bus.RS_Vk, 32'hBB);
        bus.rdy = 1'b0;
        tick();
        bus.rdy = 1'b1;
        check_eq("stall_valid", bus.RS_valid, 0);
        tick();
        check_eq("pair_second_valid", bus.RS_valid, 1);
        check_eq("pair_second_dest", bus.RS_DestRob, 2);
        check_eq("pair_second_op", bus.RS_op, OP_SUB);
        check_eq("pair_second_vk", bus.RS_Vk, 4);
        tick();
        check_eq("pair_done", bus.RS_valid, 0);
        check_eq("final_full", bus.full, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
